telemetry_tx: RTL and testbench

UART transmitter that sends robot status back over the Bluetooth link, in the opposite direction to the motor-command receiver. Every FRAME_TICKS cycles it snapshots the bump switches and the per-interval wheel-encoder edge counts, then serialises a 5-byte checksummed frame onto the Tx pin (ir_snsrch1 at top level). The top-level constant Tx tie-off is removed and this block drives Tx instead.

---
 rtl/telemetry_tx_pkg.sv | 24 ++
 rtl/telemetry_tx_uart.sv | 84 ++++++++
 rtl/telemetry_tx.sv | 137 +++++++++++++
 tb/tb_telemetry_tx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/telemetry_tx_pkg.sv
// Shared constants, serialiser state encoding and small helpers for the telemetry
// transmitter.
package telemetry_tx_pkg;

  localparam logic [7:0]  HeaderDefault = 8'hA5;
  localparam int unsigned FrameBytes    = 5;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  function automatic logic [7:0] frame_checksum(input logic [7:0] b0, input logic [7:0] b1,
                                                input logic [7:0] b2, input logic [7:0] b3);
    return b0 + b1 + b2 + b3;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/telemetry_tx_uart.sv
// Byte-level UART serialiser: start bit, 8 data bits LSB first, one stop bit.
// A start request on the final stop-bit cycle chains the next byte with no idle gap.
module uart_tx_byte
  import telemetry_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1666
) (
  input  logic       WF_CLK,
  input  logic       WF_BUTTON,
  input  logic       start,
  input  logic [7:0] data,
  output logic       Tx,
  output logic       done
);

  localparam int unsigned     BaudW    = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             tx_q, tx_d;
  logic             baud_last;
  logic             load;

  assign baud_last = (baud_q == BaudLast);
  assign load      = start && ((state_q == StIdle) || ((state_q == StStop) && baud_last));

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StStart;
      StStart: if (baud_last) state_d = StData;
      StData:  if (baud_last && (bit_q == 3'd7)) state_d = StStop;
      StStop:  if (baud_last) state_d = start ? StStart : StIdle;
    endcase
  end

  // Tx is registered, so its next value follows the next state.
  always_comb begin
    data_d = load ? data : data_q;
    baud_d = ((state_q == StIdle) || baud_last) ? '0 : baud_q + 1'b1;
    bit_d  = bit_q;
    if (state_q != StData) begin
      bit_d = '0;
    end else if (baud_last) begin
      bit_d = bit_q + 3'd1;
    end
    tx_d = 1'b1;
    unique case (state_d)
      StIdle:  tx_d = 1'b1;
      StStart: tx_d = 1'b0;
      StData:  tx_d = data_q[bit_d];
      StStop:  tx_d = 1'b1;
    endcase
    done = (state_q == StStop) && baud_last;
  end

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      baud_q <= '0;
      bit_q  <= '0;
      data_q <= '0;
      tx_q   <= 1'b1;
    end else begin
      baud_q <= baud_d;
      bit_q  <= bit_d;
      data_q <= data_d;
      tx_q   <= tx_d;
    end
  end

  assign Tx = tx_q;

endmodule

// File: rtl/telemetry_tx.sv
// Periodic robot telemetry: snapshots bump switches and per-interval encoder edge counts
// and sends a 5-byte checksummed frame over the UART Tx pin.
module telemetry_tx
  import telemetry_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1666,
  parameter int unsigned FRAME_TICKS  = 1600000,
  parameter logic [7:0]  HEADER       = HeaderDefault
) (
  input  logic       WF_CLK,
  input  logic       WF_BUTTON,
  input  logic [5:0] bump,
  input  logic       motorL_encdr,
  input  logic       motorR_encdr,
  input  logic       enable,
  output logic       Tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned      TickW    = $clog2(FRAME_TICKS);
  localparam logic [TickW-1:0] TickLast = TickW'(FRAME_TICKS - 1);

  logic [5:0]                  bump_meta_q, bump_sync_q;
  logic [1:0]                  enc_meta_q, enc_sync_q, enc_prev_q;
  logic [1:0]                  enc_edge;
  logic [7:0]                  cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
  logic [TickW-1:0]            tick_q, tick_d;
  logic [FrameBytes-1:0][7:0]  frame_q, frame_d;
  logic                        active_q, active_d;
  logic [2:0]                  byte_idx_q, byte_idx_d;
  logic [2:0]                  next_idx;
  logic                        trigger, launch, last_byte;
  logic                        byte_start, byte_done;
  logic [7:0]                  byte_data, snap_bump, snap_sum;

  // Encoder bit 0 is the left wheel, bit 1 the right wheel.
  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      bump_meta_q <= '0;
      bump_sync_q <= '0;
      enc_meta_q  <= '0;
      enc_sync_q  <= '0;
      enc_prev_q  <= '0;
    end else begin
      bump_meta_q <= bump;
      bump_sync_q <= bump_meta_q;
      enc_meta_q  <= {motorR_encdr, motorL_encdr};
      enc_sync_q  <= enc_meta_q;
      enc_prev_q  <= enc_sync_q;
    end
  end

  assign enc_edge  = enc_sync_q & ~enc_prev_q;
  assign trigger   = enable && (tick_q == TickLast);
  assign launch    = trigger && !active_q;
  assign last_byte = (byte_idx_q == 3'(FrameBytes - 1));
  assign next_idx  = byte_idx_q + 3'd1;
  assign snap_bump = {2'b00, bump_sync_q};
  assign snap_sum  = frame_checksum(HEADER, snap_bump, cnt_l_q, cnt_r_q);

  always_comb begin
    if (!enable || trigger) begin
      tick_d = '0;
    end else begin
      tick_d = tick_q + 1'b1;
    end

    // An edge in the snapshot cycle belongs to the new interval.
    if (launch) begin
      cnt_l_d = {7'd0, enc_edge[0]};
      cnt_r_d = {7'd0, enc_edge[1]};
    end else begin
      cnt_l_d = enc_edge[0] ? sat_inc8(cnt_l_q) : cnt_l_q;
      cnt_r_d = enc_edge[1] ? sat_inc8(cnt_r_q) : cnt_r_q;
    end

    frame_d = frame_q;
    if (launch) begin
      frame_d = {snap_sum, cnt_r_q, cnt_l_q, snap_bump, HEADER};
    end
  end

  always_comb begin
    active_d   = active_q;
    byte_idx_d = byte_idx_q;
    byte_start = 1'b0;
    byte_data  = HEADER;
    frame_done = 1'b0;
    if (launch) begin
      active_d   = 1'b1;
      byte_idx_d = '0;
      byte_start = 1'b1;
    end else if (active_q && byte_done) begin
      if (last_byte) begin
        active_d   = 1'b0;
        frame_done = 1'b1;
      end else begin
        byte_idx_d = next_idx;
        byte_start = 1'b1;
        byte_data  = frame_q[next_idx];
      end
    end
  end

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      tick_q     <= '0;
      cnt_l_q    <= '0;
      cnt_r_q    <= '0;
      frame_q    <= '0;
      active_q   <= 1'b0;
      byte_idx_q <= '0;
    end else begin
      tick_q     <= tick_d;
      cnt_l_q    <= cnt_l_d;
      cnt_r_q    <= cnt_r_d;
      frame_q    <= frame_d;
      active_q   <= active_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .WF_CLK   (WF_CLK),
    .WF_BUTTON(WF_BUTTON),
    .start    (byte_start),
    .data     (byte_data),
    .Tx       (Tx),
    .done     (byte_done)
  );

  assign busy = active_q;

endmodule

// File: tb/tb_telemetry_tx.sv
// Bench for telemetry_tx: table-driven frame vectors, hand-written timing corner cases and a
// randomized run, all checked against a cycle-level expected-waveform model.
module tb_telemetry_tx;

  localparam int CPB       = 4;
  localparam int FT        = 400;
  localparam int FRAME_LEN = 50 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] bump = '0;
  logic       enc_l = 1'b0;
  logic       enc_r = 1'b0;
  logic       en = 1'b0;
  logic       tx, busy, fdone;

  telemetry_tx #(
    .CLKS_PER_BIT(CPB),
    .FRAME_TICKS (FT),
    .HEADER      (8'hA5)
  ) dut (
    .WF_CLK      (clk),
    .WF_BUTTON   (rst_n),
    .bump        (bump),
    .motorL_encdr(enc_l),
    .motorR_encdr(enc_r),
    .enable      (en),
    .Tx          (tx),
    .busy        (busy),
    .frame_done  (fdone)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int stream_err = 0;
  int stream_first = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Expected Tx for the current and future cycles; empty means idle.
  bit         exp_q[$];
  int         m_tick, m_cl, m_cr;
  bit         la, lb, lc, ra, rb, rc;
  logic [5:0] bp_a, bp_b;

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_step();
    bit idle, trig, el, er;
    int bytes[5];
    if (!rst_n) begin
      exp_q.delete();
      m_tick = 0; m_cl = 0; m_cr = 0;
      la = 0; lb = 0; lc = 0; ra = 0; rb = 0; rc = 0;
      bp_a = '0; bp_b = '0;
      cyc = 0;
      return;
    end
    cyc++;
    idle = (exp_q.size() == 0);
    if (!idle) void'(exp_q.pop_front());
    trig = en && (m_tick == FT - 1);
    el = lb && !lc;
    er = rb && !rc;
    if (trig && idle) begin
      bytes[0] = 8'hA5;
      bytes[1] = int'(bp_b);
      bytes[2] = sat8(m_cl);
      bytes[3] = sat8(m_cr);
      bytes[4] = (bytes[0] + bytes[1] + bytes[2] + bytes[3]) % 256;
      for (int i = 0; i < 5; i++) begin
        repeat (CPB) exp_q.push_back(1'b0);
        for (int j = 0; j < 8; j++) repeat (CPB) exp_q.push_back(bit'((bytes[i] >> j) & 1));
        repeat (CPB) exp_q.push_back(1'b1);
      end
      m_cl = int'(el);
      m_cr = int'(er);
    end else begin
      m_cl += int'(el);
      m_cr += int'(er);
    end
    if (!en || m_tick == FT - 1) m_tick = 0;
    else m_tick++;
    lc = lb; lb = la; la = enc_l;
    rc = rb; rb = ra; ra = enc_r;
    bp_b = bp_a; bp_a = bump;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    bit e_tx, e_busy, e_fd;
    @(negedge clk);
    e_tx   = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
    e_busy = (exp_q.size() != 0);
    e_fd   = (exp_q.size() == 1);
    if (tx !== e_tx || busy !== e_busy || fdone !== e_fd) begin
      if (stream_err == 0) stream_first = cyc;
      stream_err++;
    end
  end

  task automatic check_stream(input string tag);
    chk({"stream_", tag}, stream_err, 0);
    if (stream_err != 0) $display("  first divergence from model at cycle %0d", stream_first);
    stream_err = 0;
    stream_first = -1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input logic en_v, input logic [5:0] bump_v);
    @(negedge clk);
    #2 rst_n = 1'b0;
    en = en_v; bump = bump_v; enc_l = 1'b0; enc_r = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic pulses(input int nl, input int nr);
    int n;
    n = (nl > nr) ? nl : nr;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      enc_l = (i < nl); enc_r = (i < nr);
      @(negedge clk);
      enc_l = 1'b0; enc_r = 1'b0;
    end
  endtask

  function automatic logic [4:0][7:0] mk(input logic [7:0] b1, input logic [7:0] b2,
                                         input logic [7:0] b3, input logic [7:0] b4);
    return {b4, b3, b2, b1, 8'hA5};
  endfunction

  // Captures one frame from its first start-bit cycle; decodes bytes from mid-bit samples.
  task automatic get_frame(input int limit, output logic [4:0][7:0] b, output int start,
                           output int fd_idx, output bit timing_ok, output bit found,
                           output logic busy_after);
    logic txs[FRAME_LEN];
    logic fds[FRAME_LEN];
    found = 0; b = '0; start = -1; fd_idx = -1; timing_ok = 0; busy_after = 1'b1;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1;
    end
    if (!found) return;
    start = cyc;
    txs[0] = tx; fds[0] = fdone;
    for (int n = 1; n < FRAME_LEN; n++) begin
      @(negedge clk);
      txs[n] = tx; fds[n] = fdone;
    end
    @(negedge clk);
    busy_after = busy;
    timing_ok = 1;
    for (int k = 0; k < 50; k++) begin
      for (int s = 1; s < CPB; s++) if (txs[k*CPB+s] !== txs[k*CPB]) timing_ok = 0;
      if (k % 10 == 0 && txs[k*CPB] !== 1'b0) timing_ok = 0;
      if (k % 10 == 9 && txs[k*CPB] !== 1'b1) timing_ok = 0;
    end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 8; j++) b[i][j] = txs[(i*10+1+j)*CPB + 1];
    for (int n = 0; n < FRAME_LEN; n++) if (fds[n] === 1'b1) fd_idx = (fd_idx == -1) ? n : -2;
  endtask

  task automatic check_frame(input string tag, input logic [4:0][7:0] exp, input int exp_start,
                             input int limit);
    logic [4:0][7:0] b;
    int start, fd_idx;
    bit timing_ok, found;
    logic busy_after;
    get_frame(limit, b, start, fd_idx, timing_ok, found, busy_after);
    chk({tag, "_found"}, int'(found), 1);
    chk({tag, "_start_cycle"}, start, exp_start);
    for (int i = 0; i < 5; i++) chk($sformatf("%s_b%0d", tag, i), int'(b[i]), int'(exp[i]));
    chk({tag, "_bit_timing"}, int'(timing_ok), 1);
    chk({tag, "_frame_done_pos"}, fd_idx, FRAME_LEN - 1);
    chk({tag, "_busy_after"}, int'(busy_after), 0);
  endtask

  typedef struct {
    logic [5:0] bump;
    int         nl;
    int         nr;
    logic [7:0] b1, b2, b3, b4;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int e, lows, busys, fds;
    vecs[0] = '{6'b000101, 0,   0,   8'h05, 8'h00, 8'h00, 8'hAA};
    vecs[1] = '{6'h00,     3,   7,   8'h00, 8'h03, 8'h07, 8'hAF};
    vecs[2] = '{6'h00,     300, 0,   8'h00, 8'hFF, 8'h00, 8'hA4};
    vecs[3] = '{6'h3F,     10,  20,  8'h3F, 8'h0A, 8'h14, 8'h02};
    vecs[4] = '{6'h2A,     1,   255, 8'h2A, 8'h01, 8'hFF, 8'hCF};
    vecs[5] = '{6'h12,     256, 254, 8'h12, 8'hFF, 8'hFE, 8'hB4};

    #1 rst_n = 1'b0;

    // Reset state, then first frame: trigger on cycle 399, start bit from cycle 400.
    do_reset(1'b1, 6'b000101);
    @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_done", int'(fdone), 0);
    check_frame("first", mk(8'h05, 8'h00, 8'h00, 8'hAA), 400, 450);
    check_stream("first");

    // Edges accumulated with enable low (so counts can exceed one interval's worth).
    foreach (vecs[v]) begin
      do_reset(1'b0, vecs[v].bump);
      pulses(vecs[v].nl, vecs[v].nr);
      repeat (4) @(negedge clk);
      en = 1'b1;
      e = cyc;
      check_frame($sformatf("vec%0d", v),
                  mk({2'b00, vecs[v].bump}, vecs[v].b2, vecs[v].b3, vecs[v].b4), e + FT, FT + 10);
      check_frame($sformatf("vec%0d_next", v),
                  mk({2'b00, vecs[v].bump}, 8'h00, 8'h00, 8'(8'hA5 + {2'b00, vecs[v].bump})),
                  e + 2 * FT, FT + 10);
      check_stream($sformatf("vec%0d", v));
    end

    // Reset in the middle of byte 2 aborts the frame asynchronously.
    do_reset(1'b1, 6'h11);
    while (cyc < 500) @(negedge clk);
    chk("midframe_busy_before", int'(busy), 1);
    chk("midframe_tx_before", int'(tx), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_tx_async", int'(tx), 1);
    chk("midframe_busy_async", int'(busy), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    check_frame("after_abort", mk(8'h11, 8'h00, 8'h00, 8'hB6), 400, 450);
    check_stream("abort");

    // Enable low: idle line; dropping enable mid-frame lets that frame finish, then stops.
    do_reset(1'b0, 6'h00);
    lows = 0; busys = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    chk("disabled_tx_low_cycles", lows, 0);
    chk("disabled_busy_cycles", busys, 0);
    en = 1'b1;
    repeat (450) @(negedge clk);
    chk("drop_enable_busy", int'(busy), 1);
    en = 1'b0;
    fds = 0;
    repeat (800) begin
      @(negedge clk);
      if (fdone === 1'b1) fds++;
    end
    chk("drop_enable_frame_dones", fds, 1);
    chk("drop_enable_busy_end", int'(busy), 0);
    check_stream("enable");

    // Right edge lands in cycle 398 (this frame); left edge in trigger cycle 399 (next frame).
    do_reset(1'b1, 6'h00);
    while (cyc < 396) @(negedge clk);
    enc_r = 1'b1;
    @(negedge clk);
    enc_r = 1'b0; enc_l = 1'b1;
    @(negedge clk);
    enc_l = 1'b0;
    check_frame("coincident_cur", mk(8'h00, 8'h00, 8'h01, 8'hA6), 400, 50);
    check_frame("coincident_next", mk(8'h00, 8'h01, 8'h00, 8'hA6), 800, 250);
    check_stream("coincident");

    // Randomized traffic against the model.
    do_reset(1'b1, 6'($urandom));
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) enc_l = ~enc_l;
      if ($urandom_range(0, 2) == 0) enc_r = ~enc_r;
      if ($urandom_range(0, 199) == 0) bump = 6'($urandom);
      if ($urandom_range(0, 699) == 0) en = ~en;
    end
    check_stream("random");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
